// File: rtl/gen_bank_ctrl.sv
// ---------------------------------------------------------------------------
// gen_bank_ctrl
//
// Generation-buffer controller for the cellular-automaton engine. It owns
// NUM_BANKS row-wide BRAM banks and rotates them every generation:
//   rd_bank               current generation, read by line buffer and video
//   (rd_bank+1)%NUM_BANKS next generation, written by the row compute engine
//   all other banks       older generations, left untouched
// A three-state FSM (Idle -> Compute -> WaitSwap) sequences each generation.
// The bank swap only happens on frame_start so the display never tears.
//
// Optional feature (macro STEP_EN):
//   defined   - a step pulse while paused in Idle runs exactly one generation
//   undefined - step is ignored; the board only advances while pause=0
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   pause, step       run control (level / one-cycle pulse)
//   frame_start       one-cycle pulse at vsync, the only moment a swap may occur
//   ui, ui_addr       UI takes over BRAM port b when ui=1
//   gen_start, busy   compute engine handshake
//   fetch_addr/data   line-buffer reads of the current generation (port a)
//   wr_addr/data/en   next-generation row writes (port a)
//   vid_addr/data     video reads of the current generation (port b)
//   bram_*            flattened per-bank BRAM port signals, bank k at slice k
//   rd_bank           current-generation bank index
//   gen_count         completed generations, wraps
// ---------------------------------------------------------------------------
module gen_bank_ctrl #(
    parameter int unsigned X_SIZE    = 1280,
    parameter int unsigned Y_SIZE    = 720,
    parameter int unsigned Y_WIDTH   = 10,
    parameter int unsigned NUM_BANKS = 2,
    parameter int unsigned BANK_W    = 2,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           pause,
    input  logic                           step,
    input  logic                           frame_start,
    input  logic                           ui,
    input  logic [Y_WIDTH-1:0]             ui_addr,
    output logic                           gen_start,
    output logic                           busy,
    input  logic [Y_WIDTH-1:0]             fetch_addr,
    output logic [X_SIZE-1:0]              fetch_data,
    input  logic [Y_WIDTH-1:0]             wr_addr,
    input  logic [X_SIZE-1:0]              wr_data,
    input  logic                           wr_en,
    input  logic [Y_WIDTH-1:0]             vid_addr,
    output logic [X_SIZE-1:0]              vid_data,
    output logic [NUM_BANKS*Y_WIDTH-1:0]   bram_addra,
    output logic [NUM_BANKS*X_SIZE-1:0]    bram_dina,
    output logic [NUM_BANKS-1:0]           bram_wea,
    input  logic [NUM_BANKS*X_SIZE-1:0]    bram_douta,
    output logic [NUM_BANKS*Y_WIDTH-1:0]   bram_addrb,
    input  logic [NUM_BANKS*X_SIZE-1:0]    bram_doutb,
    output logic [BANK_W-1:0]              rd_bank,
    output logic [CNT_WIDTH-1:0]           gen_count
);

    // One extra bit so the counter can never wrap inside a generation.
    localparam int unsigned RowCntW = Y_WIDTH + 1;
    localparam logic [RowCntW-1:0] LastRow = RowCntW'(Y_SIZE - 1);
    localparam logic [BANK_W-1:0] LastBank = BANK_W'(NUM_BANKS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCompute,
        StWaitSwap
    } state_e;

    state_e               state_q;
    logic [BANK_W-1:0]    rd_bank_q;
    // rd_bank_q delayed one cycle so the read mux lines up with BRAM latency.
    logic [BANK_W-1:0]    rd_bank_dly_q;
    logic [RowCntW-1:0]   row_cnt_q;
    logic [CNT_WIDTH-1:0] gen_count_q;
    logic                 gen_start_q;
    logic                 busy_q;

    logic [BANK_W-1:0]    wr_bank;
    logic                 start_go;
    logic                 write_ok;

    // ------------------------------------------------------------------
    // Start condition for a new generation out of Idle
    // ------------------------------------------------------------------
`ifdef STEP_EN
    // pause=0 runs freely; a step while paused runs exactly one generation,
    // after which the FSM lands back in Idle with pause still high.
    assign start_go = !pause || step;
`else
    logic unused_step;
    assign unused_step = step;
    assign start_go    = !pause;
`endif

    // ------------------------------------------------------------------
    // Write bank: the bank after rd_bank, modulo NUM_BANKS
    // ------------------------------------------------------------------
    always_comb begin
        wr_bank = '0;
        if (rd_bank_q != LastBank) begin
            wr_bank = rd_bank_q + 1'b1;
        end
    end

    // Writes only land while computing; Idle and WaitSwap drop stray strobes.
    // Gating with rst keeps every wea low in the reset cycle itself.
    assign write_ok = wr_en && (state_q == StCompute) && !rst;

    // ------------------------------------------------------------------
    // Sequencing FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            rd_bank_q     <= '0;
            rd_bank_dly_q <= '0;
            row_cnt_q     <= '0;
            gen_count_q   <= '0;
            gen_start_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            gen_start_q   <= 1'b0;
            rd_bank_dly_q <= rd_bank_q;
            unique case (state_q)
                StIdle: begin
                    if (start_go) begin
                        state_q     <= StCompute;
                        gen_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        row_cnt_q   <= '0;
                    end
                end
                StCompute: begin
                    // pause is not looked at here: a started generation always
                    // runs to completion.
                    if (wr_en) begin
                        row_cnt_q <= row_cnt_q + 1'b1;
                        if (row_cnt_q == LastRow) begin
                            state_q <= StWaitSwap;
                        end
                    end
                end
                StWaitSwap: begin
                    // A frame_start coinciding with the last row write arrives
                    // while still in Compute and is therefore not honoured.
                    if (frame_start) begin
                        rd_bank_q   <= wr_bank;
                        gen_count_q <= gen_count_q + 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Per-bank BRAM port wiring
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
        localparam logic [BANK_W-1:0] BankIdx = BANK_W'(k);

        // Port a: the write bank follows wr_addr, every other bank follows
        // fetch_addr (only rd_bank's data is ever selected from them).
        assign bram_addra[k*Y_WIDTH +: Y_WIDTH] = (wr_bank == BankIdx) ? wr_addr : fetch_addr;
        assign bram_dina[k*X_SIZE +: X_SIZE]    = wr_data;
        assign bram_wea[k]                      = write_ok && (wr_bank == BankIdx);

        // Port b is read only and shared between UI and video.
        assign bram_addrb[k*Y_WIDTH +: Y_WIDTH] = ui ? ui_addr : vid_addr;
    end

    // ------------------------------------------------------------------
    // Read data mux, steered by the delayed bank index
    // ------------------------------------------------------------------
    always_comb begin
        fetch_data = '0;
        vid_data   = '0;
        for (int unsigned k = 0; k < NUM_BANKS; k++) begin
            if (rd_bank_dly_q == BANK_W'(k)) begin
                fetch_data = bram_douta[k*X_SIZE +: X_SIZE];
                vid_data   = bram_doutb[k*X_SIZE +: X_SIZE];
            end
        end
    end

    assign gen_start = gen_start_q;
    assign busy      = busy_q;
    assign rd_bank   = rd_bank_q;
    assign gen_count = gen_count_q;

endmodule

// File: tb/tb_gen_bank_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gen_bank_ctrl
//
// Directed bench for gen_bank_ctrl. Instance A: 2 banks, 720 rows, 16-bit
// rows. Instance B: 3 banks, 4 rows. Each BRAM is modelled as a one-cycle
// read returning a tag pattern built from {port, bank, address}.
// ---------------------------------------------------------------------------
module tb_gen_bank_ctrl;

    localparam int XS = 16;
    localparam int YW = 10;

`ifdef STEP_EN
    localparam logic [1:0]  StepRdBank = 2'd1;
    localparam logic [15:0] StepGenCnt = 16'd3;
    localparam int          StepGs     = 1;
`else
    localparam logic [1:0]  StepRdBank = 2'd0;
    localparam logic [15:0] StepGenCnt = 16'd2;
    localparam int          StepGs     = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- instance A ----------------
    logic              a_rst, a_pause, a_step, a_frame_start, a_ui, a_wr_en;
    logic [YW-1:0]     a_ui_addr, a_fetch_addr, a_wr_addr, a_vid_addr;
    logic [XS-1:0]     a_wr_data, a_fetch_data, a_vid_data;
    logic              a_gen_start, a_busy;
    logic [2*YW-1:0]   a_addra, a_addrb;
    logic [2*XS-1:0]   a_dina, a_douta, a_doutb;
    logic [1:0]        a_wea;
    logic [1:0]        a_rd_bank;
    logic [15:0]       a_gen_count;

    gen_bank_ctrl #(
        .X_SIZE(XS), .Y_SIZE(720), .Y_WIDTH(YW), .NUM_BANKS(2), .BANK_W(2), .CNT_WIDTH(16)
    ) u_dut_a (
        .clk(clk), .rst(a_rst), .pause(a_pause), .step(a_step), .frame_start(a_frame_start),
        .ui(a_ui), .ui_addr(a_ui_addr), .gen_start(a_gen_start), .busy(a_busy),
        .fetch_addr(a_fetch_addr), .fetch_data(a_fetch_data), .wr_addr(a_wr_addr),
        .wr_data(a_wr_data), .wr_en(a_wr_en), .vid_addr(a_vid_addr), .vid_data(a_vid_data),
        .bram_addra(a_addra), .bram_dina(a_dina), .bram_wea(a_wea), .bram_douta(a_douta),
        .bram_addrb(a_addrb), .bram_doutb(a_doutb), .rd_bank(a_rd_bank),
        .gen_count(a_gen_count)
    );

    // ---------------- instance B ----------------
    logic              b_rst, b_pause, b_step, b_frame_start, b_ui, b_wr_en;
    logic [2:0]        b_ui_addr, b_fetch_addr, b_wr_addr, b_vid_addr;
    logic [XS-1:0]     b_wr_data, b_fetch_data, b_vid_data;
    logic              b_gen_start, b_busy;
    logic [8:0]        b_addra, b_addrb;
    logic [3*XS-1:0]   b_dina;
    logic [3*XS-1:0]   b_douta = '0;
    logic [3*XS-1:0]   b_doutb = '0;
    logic [2:0]        b_wea;
    logic [1:0]        b_rd_bank;
    logic [15:0]       b_gen_count;

    gen_bank_ctrl #(
        .X_SIZE(XS), .Y_SIZE(4), .Y_WIDTH(3), .NUM_BANKS(3), .BANK_W(2), .CNT_WIDTH(16)
    ) u_dut_b (
        .clk(clk), .rst(b_rst), .pause(b_pause), .step(b_step), .frame_start(b_frame_start),
        .ui(b_ui), .ui_addr(b_ui_addr), .gen_start(b_gen_start), .busy(b_busy),
        .fetch_addr(b_fetch_addr), .fetch_data(b_fetch_data), .wr_addr(b_wr_addr),
        .wr_data(b_wr_data), .wr_en(b_wr_en), .vid_addr(b_vid_addr), .vid_data(b_vid_data),
        .bram_addra(b_addra), .bram_dina(b_dina), .bram_wea(b_wea), .bram_douta(b_douta),
        .bram_addrb(b_addrb), .bram_doutb(b_doutb), .rd_bank(b_rd_bank),
        .gen_count(b_gen_count)
    );

    // Tag pattern returned by the BRAM model: {port_a, bank[2:0], 2'b00, addr}.
    function automatic logic [15:0] pat(input logic a, input int k, input logic [9:0] addr);
        logic [2:0] kb;
        kb = k[2:0];
        return {a, kb, 2'b00, addr};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            a_douta[k*XS +: XS] <= pat(1'b1, k, a_addra[k*YW +: YW]);
            a_doutb[k*XS +: XS] <= pat(1'b0, k, a_addrb[k*YW +: YW]);
        end
    end

    // Event counters sampled mid-cycle.
    int a_wea0_n = 0, a_wea1_n = 0, a_gs_n = 0;
    int b_wea0_n = 0, b_wea1_n = 0, b_wea2_n = 0;
    always @(negedge clk) begin
        if (a_wea[0] === 1'b1) a_wea0_n++;
        if (a_wea[1] === 1'b1) a_wea1_n++;
        if (a_gen_start === 1'b1) a_gs_n++;
        if (b_wea[0] === 1'b1) b_wea0_n++;
        if (b_wea[1] === 1'b1) b_wea1_n++;
        if (b_wea[2] === 1'b1) b_wea2_n++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int base0, base1, base_gs, bb0, bb1, bb2;
    logic [1:0] b_exp_bank;

    initial begin
        a_rst = 1'b1; a_pause = 1'b0; a_step = 1'b0; a_frame_start = 1'b0; a_ui = 1'b0;
        a_wr_en = 1'b0; a_ui_addr = '0; a_fetch_addr = '0; a_wr_addr = '0; a_vid_addr = '0;
        a_wr_data = '0;
        b_rst = 1'b1; b_pause = 1'b0; b_step = 1'b0; b_frame_start = 1'b0; b_ui = 1'b0;
        b_wr_en = 1'b0; b_ui_addr = '0; b_fetch_addr = '0; b_wr_addr = '0; b_vid_addr = '0;
        b_wr_data = '0;

        tick();
        tick();
        chk("rst_gen_start", a_gen_start, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_rd_bank", a_rd_bank, 0);
        chk("rst_gen_count", a_gen_count, 0);
        chk("rst_wea", a_wea, 0);
        chk("b_rst_rd_bank", b_rd_bank, 0);

        // Generation 1: gen_start one cycle after reset release.
        a_rst = 1'b0;
        tick();
        chk("gen1_gen_start", a_gen_start, 1);
        chk("gen1_busy", a_busy, 1);
        a_wr_data = 16'hA5C3;
        #1;
        chk("dina_all_banks", a_dina, {2{16'hA5C3}});
        base0 = a_wea0_n;
        base1 = a_wea1_n;
        for (int r = 0; r < 720; r++) begin
            a_wr_addr = YW'(r);
            a_wr_en = 1'b1;
            a_fetch_addr = 10'd7;
            #1;
            if (r == 0) begin
                chk("gen1_addra_wr", a_addra[YW +: YW], 0);
                chk("gen1_addra_fetch", a_addra[0 +: YW], 7);
                chk("gen1_wea", a_wea, 2'b10);
            end
            if (r == 1) begin
                chk("gen1_gen_start_pulse", a_gen_start, 0);
                chk("gen1_fetch_data", a_fetch_data, pat(1'b1, 0, 10'd7));
            end
            tick();
        end
        a_wr_en = 1'b0;
        #1;
        chk("gen1_wea1_count", a_wea1_n - base1, 720);
        chk("gen1_wea0_count", a_wea0_n - base0, 0);
        chk("wait_busy", a_busy, 1);
        chk("wait_rd_bank", a_rd_bank, 0);

        // Stray write in WaitSwap must not reach any bank.
        a_wr_en = 1'b1;
        a_wr_addr = 10'd3;
        #1;
        chk("wait_wr_ignored", a_wea, 0);
        tick();
        a_wr_en = 1'b0;

        // Port b under UI control, then the swap and the delayed read mux.
        a_ui = 1'b1;
        a_ui_addr = 10'd5;
        a_vid_addr = 10'd300;
        #1;
        chk("addrb_ui", a_addrb, {10'd5, 10'd5});
        tick();
        chk("vid_data_bank0", a_vid_data, pat(1'b0, 0, 10'd5));
        a_frame_start = 1'b1;
        tick();
        a_frame_start = 1'b0;
        chk("swap1_rd_bank", a_rd_bank, 1);
        chk("swap1_gen_count", a_gen_count, 1);
        chk("swap1_busy", a_busy, 0);
        chk("swap1_vid_data_lag", a_vid_data, pat(1'b0, 0, 10'd5));
        tick();
        chk("gen2_gen_start", a_gen_start, 1);
        chk("swap1_vid_data_follow", a_vid_data, pat(1'b0, 1, 10'd5));
        a_ui = 1'b0;
        #1;
        chk("addrb_vid", a_addrb, {10'd300, 10'd300});

        // Generation 2: frame_start together with the final row write.
        for (int r = 0; r < 720; r++) begin
            a_wr_addr = YW'(r);
            a_wr_en = 1'b1;
            a_frame_start = (r == 719);
            #1;
            if (r == 0) chk("gen2_wea", a_wea, 2'b01);
            tick();
        end
        a_wr_en = 1'b0;
        a_frame_start = 1'b0;
        chk("fs_coincident_rd_bank", a_rd_bank, 1);
        chk("fs_coincident_busy", a_busy, 1);
        a_pause = 1'b1;
        tick();
        chk("fs_coincident_hold", a_rd_bank, 1);
        a_frame_start = 1'b1;
        tick();
        a_frame_start = 1'b0;
        chk("swap2_rd_bank", a_rd_bank, 0);
        chk("swap2_gen_count", a_gen_count, 2);

        // Paused in Idle for 5000 cycles.
        base_gs = a_gs_n;
        for (int i = 0; i < 5000; i++) tick();
        a_wr_en = 1'b1;
        #1;
        chk("idle_wr_ignored", a_wea, 0);
        tick();
        a_wr_en = 1'b0;
        chk("pause_no_gen_start", a_gs_n - base_gs, 0);
        chk("pause_rd_bank", a_rd_bank, 0);
        chk("pause_busy", a_busy, 0);

        // Single step while paused.
        a_step = 1'b1;
        tick();
        a_step = 1'b0;
`ifdef STEP_EN
        chk("step_gen_start", a_gen_start, 1);
        for (int r = 0; r < 720; r++) begin
            a_wr_addr = YW'(r);
            a_wr_en = 1'b1;
            tick();
        end
        a_wr_en = 1'b0;
        a_frame_start = 1'b1;
        tick();
        a_frame_start = 1'b0;
`endif
        for (int i = 0; i < 10; i++) tick();
        chk("step_gen_start_count", a_gs_n - base_gs, StepGs);
        chk("step_rd_bank", a_rd_bank, StepRdBank);
        chk("step_gen_count", a_gen_count, StepGenCnt);
        chk("step_idle", a_busy, 0);

        // Reset in the middle of a generation.
        a_pause = 1'b0;
        tick();
        chk("rstmid_gen_start", a_gen_start, 1);
        for (int r = 0; r < 400; r++) begin
            a_wr_addr = YW'(r);
            a_wr_en = 1'b1;
            tick();
        end
        a_rst = 1'b1;
        a_wr_addr = 10'd400;
        #1;
        chk("rstmid_wea", a_wea, 0);
        tick();
        a_rst = 1'b0;
        a_wr_en = 1'b0;
        #1;
        chk("rstmid_busy", a_busy, 0);
        chk("rstmid_rd_bank", a_rd_bank, 0);
        chk("rstmid_gen_count", a_gen_count, 0);
        chk("rstmid_gen_start", a_gen_start, 0);
        tick();
        chk("rstmid_restart", a_gen_start, 1);
        for (int r = 0; r < 719; r++) begin
            a_wr_addr = YW'(r);
            a_wr_en = 1'b1;
            tick();
        end
        chk("rstmid_row719_busy", a_busy, 1);
        a_wr_addr = 10'd719;
        #1;
        chk("rstmid_row_cnt_from_0", a_wea, 2'b10);
        tick();
        a_wr_addr = 10'd0;
        #1;
        chk("rstmid_done_no_wea", a_wea, 0);
        tick();
        a_wr_en = 1'b0;

        // Instance B: three banks rotate 1, 2, 0.
        b_rst = 1'b0;
        bb0 = b_wea0_n;
        bb1 = b_wea1_n;
        bb2 = b_wea2_n;
        tick();
        chk("b_gen_start", b_gen_start, 1);
        b_exp_bank = 2'd1;
        for (int g = 0; g < 3; g++) begin
            for (int r = 0; r < 4; r++) begin
                b_wr_addr = 3'(r);
                b_wr_en = 1'b1;
                tick();
            end
            b_wr_en = 1'b0;
            b_frame_start = 1'b1;
            tick();
            b_frame_start = 1'b0;
            chk("b_rd_bank_seq", b_rd_bank, b_exp_bank);
            if (g == 1) chk("b_bank0_untouched", b_wea0_n - bb0, 0);
            b_exp_bank = (b_exp_bank == 2'd2) ? 2'd0 : b_exp_bank + 2'd1;
            tick();
            chk("b_next_gen_start", b_gen_start, 1);
        end
        chk("b_wea0_count", b_wea0_n - bb0, 4);
        chk("b_wea1_count", b_wea1_n - bb1, 4);
        chk("b_wea2_count", b_wea2_n - bb2, 4);
        chk("b_gen_count", b_gen_count, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gen_bank_ctrl.md
Name: gen_bank_ctrl

Overview:
- Generation-buffer controller for the cellular-automaton engine.
- Sits between the row compute engine, line buffer, video output and UI on one side, and NUM_BANKS row-wide BRAMs on the other.
- Rotates BRAM banks per generation and sequences each generation with an FSM.
- Bank swaps occur only at frame boundaries (tear-free); pause is supported, with optional single-step.

Parameters:
- X_SIZE, 1280: row width in cells (BRAM data width).
- Y_SIZE, 720: rows per generation.
- Y_WIDTH, 10: row address width.
- NUM_BANKS, 2: number of BRAM banks, legal 2..4.
- BANK_W, 2: bank index width.
- CNT_WIDTH, 16: generation counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- pause  in  1  level; holds the board at the current generation.
- step  in  1  one-cycle pulse; advance one generation while paused (STEP_EN only).
- frame_start  in  1  one-cycle pulse at vsync.
- ui  in  1  UI owns BRAM port b when high.
- ui_addr  in  Y_WIDTH  UI row address.
- gen_start  out  1  one-cycle pulse; compute engine begins a generation.
- busy  out  1  high in COMPUTE and WAIT_SWAP.
- fetch_addr  in  Y_WIDTH  line-buffer row read address.
- fetch_data  out  X_SIZE  line-buffer row data.
- wr_addr  in  Y_WIDTH  next-state row address.
- wr_data  in  X_SIZE  next-state row data.
- wr_en  in  1  next-state row write strobe.
- vid_addr  in  Y_WIDTH  video row address.
- vid_data  out  X_SIZE  video row data.
- bram_addra  out  NUM_BANKS*Y_WIDTH  port-a addresses, bank k at slice k.
- bram_dina  out  NUM_BANKS*X_SIZE  port-a write data.
- bram_wea  out  NUM_BANKS  port-a write enables.
- bram_douta  in  NUM_BANKS*X_SIZE  port-a read data.
- bram_addrb  out  NUM_BANKS*Y_WIDTH  port-b addresses (read only).
- bram_doutb  in  NUM_BANKS*X_SIZE  port-b read data.
- rd_bank  out  BANK_W  current-generation bank index.
- gen_count  out  CNT_WIDTH  completed generations, wraps modulo 2^CNT_WIDTH.

Behaviour:
- Bank roles:
  - rd_bank holds the current generation; the line buffer and video read it.
  - wr_bank = (rd_bank+1) mod NUM_BANKS receives the next generation.
  - Other banks retain older generations, untouched.
- Port a:
  - Every bank's addra = wr_addr if bank==wr_bank, else fetch_addr.
  - dina = wr_data on all banks.
  - bram_wea[wr_bank] = wr_en only in COMPUTE; all other wea bits are always 0.
  - rd_bank is never written.
- Port b: every bank's addrb = ui ? ui_addr : vid_addr.
- Read data path:
  - fetch_data = douta[rd_bank_q], vid_data = doutb[rd_bank_q].
  - rd_bank_q is rd_bank delayed one cycle, matching the one-cycle BRAM read latency.
  - Data for an address presented at cycle t is valid at t+1.
- FSM states: IDLE, COMPUTE, WAIT_SWAP.
- IDLE:
  - Enter COMPUTE when pause=0, or when pause=1 and step=1 (STEP_EN).
  - gen_start=1 on the transition cycle; row_cnt cleared to 0.
- COMPUTE:
  - Each wr_en increments row_cnt.
  - wr_en with row_cnt==Y_SIZE-1 moves to WAIT_SWAP.
  - pause asserted mid-generation does not abort; the generation completes.
- WAIT_SWAP:
  - wr_en is ignored (no wea, no count).
  - On frame_start: rd_bank <= wr_bank, gen_count += 1, go to IDLE.
  - A frame_start in the same cycle as the final row write is not honoured; the swap waits for the next frame_start.
- IDLE after swap with pause=0 immediately re-enters COMPUTE: one IDLE cycle between swap and the next gen_start.
- wr_en in IDLE is ignored.
- row_cnt width: Y_WIDTH+1 bits; no wrap inside a generation.
- Reset, including mid-generation: state=IDLE, rd_bank=0, rd_bank_q=0, row_cnt=0, gen_count=0, gen_start=0, busy=0, all wea=0.
  - Partially written bank contents are undefined and never displayed.

Optional Feature:
- Macro STEP_EN.
- Defined: step while pause=1 in IDLE runs exactly one generation, then remains paused in IDLE. step while pause=0, or outside IDLE, is ignored.
- Undefined: step port present but ignored; the board advances only when pause=0.

Test Plan:
- Reset, NUM_BANKS=2, pause=0 -> gen_start pulse 1 cycle after rst release; 720 wr_en pulses to rows 0..719 -> bram_wea[1] pulses 720 times, wea[0] never; frame_start -> rd_bank=1, gen_count=1.
- NUM_BANKS=3, three full generations -> rd_bank sequence 1,2,0; bank 0 written only in the third generation; gen_count=3.
- frame_start coincident with row 719 write -> rd_bank unchanged; next frame_start swaps; extra wr_en in WAIT_SWAP -> no wea asserted.
- pause=1 in IDLE for 5000 cycles -> no gen_start, rd_bank constant; STEP_EN: one step pulse -> exactly one generation, then IDLE, gen_count+1.
- ui=1, ui_addr=5, vid_addr=300 -> all addrb=5, vid_data = doutb[rd_bank] of row 5 one cycle later; rd_bank swap -> mux follows one cycle after rd_bank changes.
- rst asserted at row 400 of COMPUTE -> next cycle IDLE, rd_bank=0, gen_count=0, all wea=0; a new generation starts cleanly with row_cnt from 0.
